// File: rtl/obi_dma_copy.sv
// OBI manager that copies LEN words from SRC to DST, one read then one write per word.
// Optional fill mode (writes a constant pattern, no reads) is enabled by defining OBI_DMA_FILL_EN.
module obi_dma_copy #(
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
`ifdef OBI_DMA_FILL_EN
    input  logic                 fill_i,
    input  logic [31:0]          fill_value_i,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic                 m_req_o,
    input  logic                 m_gnt_i,
    output logic [31:0]          m_addr_o,
    output logic                 m_we_o,
    output logic [3:0]           m_be_o,
    output logic [31:0]          m_wdata_o,
    input  logic                 m_rvalid_i,
    input  logic [31:0]          m_rdata_i
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_RESP = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]           state_q;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [31:0]          wdata_q;
    logic                 error_q;
    logic                 fill_q;
    logic                 fill_start;
    logic [31:0]          fill_value;

`ifdef OBI_DMA_FILL_EN
    assign fill_start = fill_i;
    assign fill_value = fill_value_i;
`else
    assign fill_start = 1'b0;
    assign fill_value = 32'h0;
`endif

    // In fill mode the pattern is parked in the write-data register at start and never replaced.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            wdata_q     <= '0;
            error_q     <= 1'b0;
            fill_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        src_q       <= src_addr_i & 32'hFFFF_FFFC;
                        dst_q       <= dst_addr_i & 32'hFFFF_FFFC;
                        remaining_q <= len_i;
                        timer_q     <= '0;
                        error_q     <= 1'b0;
                        fill_q      <= fill_start;
                        if (fill_start) begin
                            wdata_q <= fill_value;
                        end
                        if (len_i == '0) begin
                            state_q <= ST_FINISH;
                        end else if (fill_start) begin
                            state_q <= ST_WR_REQ;
                        end else begin
                            state_q <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (m_gnt_i) begin
                        timer_q <= '0;
                        state_q <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (m_rvalid_i) begin
                        wdata_q <= m_rdata_i;
                        state_q <= ST_WR_REQ;
                    end else if (timer_q == TIMER_LAST) begin
                        error_q <= 1'b1;
                        state_q <= ST_FINISH;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    if (m_gnt_i) begin
                        src_q       <= src_q + 32'd4;
                        dst_q       <= dst_q + 32'd4;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            state_q <= ST_FINISH;
                        end else if (fill_q) begin
                            state_q <= ST_WR_REQ;
                        end else begin
                            state_q <= ST_RD_REQ;
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        m_addr_o = 32'h0;
        if (state_q == ST_RD_REQ) begin
            m_addr_o = src_q;
        end else if (state_q == ST_WR_REQ) begin
            m_addr_o = dst_q;
        end
    end

    assign m_req_o   = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign m_we_o    = (state_q == ST_WR_REQ);
    assign m_be_o    = 4'hF;
    assign m_wdata_o = wdata_q;
    assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done_o    = (state_q == ST_FINISH);
    assign error_o   = error_q;

endmodule

// File: tb/tb_obi_dma_copy.sv
// Directed bench for obi_dma_copy: SRAM responder model with optional grant backpressure
// and rvalid suppression; fill checks run only when OBI_DMA_FILL_EN is defined.
module tb_obi_dma_copy;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        fill_i = 1'b0;
    logic [31:0] fill_value_i = '0;
    logic        busy_o, done_o, error_o;
    logic        m_req_o, m_we_o;
    logic        m_gnt_i = 1'b0;
    logic [31:0] m_addr_o, m_wdata_o;
    logic [3:0]  m_be_o;
    logic        m_rvalid_i = 1'b0;
    logic [31:0] m_rdata_i = '0;

    obi_dma_copy #(.LEN_WIDTH(16), .TIMEOUT_CYCLES(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
`ifdef OBI_DMA_FILL_EN
        .fill_i(fill_i), .fill_value_i(fill_value_i),
`endif
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o), .m_we_o(m_we_o),
        .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    bit          bp_en = 1'b0;
    bit          rvalid_en = 1'b1;
    int          wait_left = 0;
    bit          pend = 1'b0;
    bit          pend_we = 1'b0;
    logic [31:0] pend_addr = '0, pend_wdata = '0;
    bit          stalled = 1'b0;
    logic [31:0] st_addr = '0, st_wdata = '0;
    bit          st_we = 1'b0;
    int          rd_count = 0, wr_count = 0, stall_cycles = 0, stall_violations = 0, be_bad = 0;
    bit          req_seen = 1'b0;
    logic [31:0] last_wr_addr = '0;

    // Responder works on the falling edge: it completes the handshake of the previous cycle
    // (write into memory or one-cycle-later rvalid) and then decides the grant for this one.
    always @(negedge clk_i) begin
        m_rvalid_i = 1'b0;
        if (pend) begin
            if (pend_we) begin
                mem[pend_addr[9:2]] = pend_wdata;
                wr_count++;
                last_wr_addr = pend_addr;
            end else begin
                rd_count++;
                if (rvalid_en) begin
                    m_rvalid_i = 1'b1;
                    m_rdata_i  = mem[pend_addr[9:2]];
                end
            end
            pend = 1'b0;
        end
        if (stalled && !(m_req_o === 1'b1 && m_addr_o === st_addr && m_we_o === st_we &&
                         m_wdata_o === st_wdata)) begin
            stall_violations++;
        end
        stalled = 1'b0;
        if (m_req_o) begin
            req_seen = 1'b1;
            if (m_be_o !== 4'hF) be_bad++;
            if (wait_left > 0) begin
                m_gnt_i  = 1'b0;
                wait_left--;
                stall_cycles++;
                stalled  = 1'b1;
                st_addr  = m_addr_o;
                st_we    = m_we_o;
                st_wdata = m_wdata_o;
            end else begin
                m_gnt_i    = 1'b1;
                pend       = 1'b1;
                pend_we    = m_we_o;
                pend_addr  = m_addr_o;
                pend_wdata = m_wdata_o;
                wait_left  = bp_en ? int'($urandom_range(1, 5)) : 0;
            end
        end else begin
            m_gnt_i = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic resetStats();
        @(posedge clk_i);
        #1;
        rd_count = 0; wr_count = 0; stall_cycles = 0; stall_violations = 0;
        be_bad = 0; req_seen = 1'b0; wait_left = 0; pend = 1'b0; stalled = 1'b0;
    endtask

    // Pulses start and returns the cycle index (start cycle = 0) at which done_o is seen.
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                                 input logic [15:0] len, input logic fill,
                                 input logic [31:0] fval, output int cycles,
                                 output logic busy1, output logic err1);
        tick();
        start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = len;
        fill_i = fill; fill_value_i = fval;
        tick();
        start_i = 1'b0;
        cycles = 1;
        busy1 = busy_o;
        err1 = error_o;
        while (!done_o && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   cyc;
        logic b1, e1;
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 + i;
        mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
        for (int i = 0; i < 4; i++) mem[4 + i] = 32'h1111_0000 + i;

        #1 rst_ni = 1'b0;
        #1;
        checkOutput("reset_req", m_req_o, 1'b0);
        checkOutput("reset_busy", busy_o, 1'b0);
        checkOutput("reset_be", m_be_o, 4'hF);
        repeat (3) tick();
        rst_ni = 1'b1;
        resetStats();

        // Copy of four words, 3 cycles per word plus FINISH.
        applyStimulus(32'h8000_0000, 32'h8000_0100, 16'd4, 1'b0, 32'h0, cyc, b1, e1);
        checkOutput("copy_busy_c1", b1, 1'b1);
        checkOutput("copy_done", done_o, 1'b1);
        checkOutput("copy_latency", cyc, 13);
        checkOutput("copy_busy_at_done", busy_o, 1'b0);
        checkOutput("copy_error", error_o, 1'b0);
        tick();
        checkOutput("copy_done_pulse", done_o, 1'b0);
        for (int i = 0; i < 4; i++) checkOutput("copy_data", mem[64 + i], i + 1);
        checkOutput("copy_reads", rd_count, 4);
        checkOutput("copy_writes", wr_count, 4);
        checkOutput("copy_be", be_bad, 0);

        // Grant backpressure with unaligned addresses that must be word-aligned.
        resetStats();
        bp_en = 1'b1;
        wait_left = 3;
        applyStimulus(32'h8000_0011, 32'h8000_0183, 16'd4, 1'b0, 32'h0, cyc, b1, e1);
        checkOutput("bp_done", done_o, 1'b1);
        tick();
        bp_en = 1'b0;
        for (int i = 0; i < 4; i++) checkOutput("bp_data", mem[96 + i], 32'h1111_0000 + i);
        checkOutput("bp_stable", stall_violations, 0);
        checkOutput("bp_stalled", (stall_cycles > 0) ? 1 : 0, 1);
        checkOutput("bp_error", error_o, 1'b0);

        // Destination wraps past 0xFFFF_FFFC to 0x0000_0000.
        resetStats();
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFC, 16'd2, 1'b0, 32'h0, cyc, b1, e1);
        checkOutput("wrap_latency", cyc, 7);
        tick();
        checkOutput("wrap_word0", mem[255], 32'd1);
        checkOutput("wrap_word1", mem[0], 32'd2);
        checkOutput("wrap_last_addr", last_wr_addr, 32'h0000_0000);

        // Zero length: FINISH straight away, no bus request.
        resetStats();
        applyStimulus(32'h8000_0000, 32'h8000_0300, 16'd0, 1'b0, 32'h0, cyc, b1, e1);
        checkOutput("len0_latency", cyc, 1);
        checkOutput("len0_busy", busy_o, 1'b0);
        tick();
        checkOutput("len0_no_req", req_seen, 1'b0);

        // A second start while busy must be ignored.
        resetStats();
        mem[160] = 32'h5A5A_5A5A;
        tick();
        start_i = 1'b1; src_addr_i = 32'h8000_0000; dst_addr_i = 32'h8000_0200; len_i = 16'd2;
        tick();
        start_i = 1'b1; dst_addr_i = 32'h8000_0280; len_i = 16'd5;
        tick();
        start_i = 1'b0;
        cyc = 2;
        while (!done_o && cyc < 200) begin
            tick();
            cyc++;
        end
        checkOutput("busy_start_latency", cyc, 7);
        tick();
        checkOutput("busy_start_writes", wr_count, 2);
        checkOutput("busy_start_dst", mem[128], 32'd2);
        checkOutput("busy_start_ignored", mem[160], 32'h5A5A_5A5A);

        // Read response never arrives: abort after 64 waiting cycles, sticky error.
        resetStats();
        rvalid_en = 1'b0;
        mem[200] = 32'h7777_7777;
        applyStimulus(32'h8000_0000, 32'h8000_0320, 16'd2, 1'b0, 32'h0, cyc, b1, e1);
        checkOutput("to_latency", cyc, 66);
        checkOutput("to_error", error_o, 1'b1);
        repeat (3) tick();
        checkOutput("to_error_sticky", error_o, 1'b1);
        checkOutput("to_no_write", wr_count, 0);
        checkOutput("to_untouched", mem[200], 32'h7777_7777);
        rvalid_en = 1'b1;
        resetStats();
        applyStimulus(32'h8000_0004, 32'h8000_0320, 16'd1, 1'b0, 32'h0, cyc, b1, e1);
        checkOutput("to_error_cleared", e1, 1'b0);
        checkOutput("to_retry_latency", cyc, 4);
        tick();
        checkOutput("to_retry_data", mem[200], 32'd2);

`ifdef OBI_DMA_FILL_EN
        resetStats();
        applyStimulus(32'h8000_0000, 32'h8000_0200, 16'd8, 1'b1, 32'hA5A5_A5A5, cyc, b1, e1);
        checkOutput("fill_latency", cyc, 9);
        tick();
        for (int i = 0; i < 8; i++) checkOutput("fill_data", mem[128 + i], 32'hA5A5_A5A5);
        checkOutput("fill_reads", rd_count, 0);
        checkOutput("fill_writes", wr_count, 8);
        fill_i = 1'b0;
`endif

        // Asynchronous reset in the middle of a write request.
        resetStats();
        tick();
        start_i = 1'b1; src_addr_i = 32'h8000_0000; dst_addr_i = 32'h8000_0300; len_i = 16'd3;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        checkOutput("mid_pre_we", m_we_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("mid_req", m_req_o, 1'b0);
        checkOutput("mid_we", m_we_o, 1'b0);
        checkOutput("mid_addr", m_addr_o, 32'h0);
        checkOutput("mid_wdata", m_wdata_o, 32'h0);
        checkOutput("mid_busy", busy_o, 1'b0);
        checkOutput("mid_done", done_o, 1'b0);
        checkOutput("mid_error", error_o, 1'b0);
        checkOutput("mid_be", m_be_o, 4'hF);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("mid_no_done", done_o, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
